// File: rtl/pe_pc_sequencer.sv
// pe_pc_sequencer: per-PE program sequencer (PC, fetch, scalar/vector/stream-out stepping).
// Optional taken-branch loop guard is enabled by defining PC_LOOP_GUARD_EN.
module pe_pc_sequencer #(
   parameter int PC_W       = 12,
   parameter int VLEN_W     = 16,
   parameter int STEADY_LAT = 4
`ifdef PC_LOOP_GUARD_EN
   ,
   parameter int MAX_TAKEN  = 1024
`endif
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              start,
   input  logic [PC_W-1:0]   end_pc,
   input  logic [VLEN_W-1:0] vlen,
   input  logic              is_not_vect,
   input  logic              is_bne,
   input  logic              flag_neq,
   input  logic              is_vstreamout,
   input  logic [PC_W-1:0]   branch_immediate,
   input  logic              so_ready,
   output logic [PC_W-1:0]   pc,
   output logic              imem_rd_en,
   output logic              vec_valid,
   output logic [VLEN_W-1:0] vec_idx,
   output logic              done_auto_incr,
   output logic              streamout_incr,
   output logic              done_steady,
   output logic              busy,
`ifdef PC_LOOP_GUARD_EN
   output logic              loop_err,
`endif
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_STEADY,
      S_DONE
   } state_t;

   localparam int SL_W = (STEADY_LAT < 2) ? 1 : $clog2(STEADY_LAT);
   localparam logic [SL_W-1:0] SL_LOAD =
      (STEADY_LAT > 0) ? SL_W'(STEADY_LAT - 1) : '0;

`ifdef PC_LOOP_GUARD_EN
   localparam int TK_W = ($clog2(MAX_TAKEN + 1) < 1) ? 1 : $clog2(MAX_TAKEN + 1);
   localparam logic [TK_W-1:0] TK_MAX = TK_W'(MAX_TAKEN);

   logic [TK_W-1:0] taken_q, taken_d;
   logic            err_q, err_d;
`endif

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [VLEN_W-1:0] idx_q, idx_d;
   logic [SL_W-1:0]   stdy_q, stdy_d;

   logic              vlen_zero;
   logic              last_idx;
   logic              accept;
   logic              fin_vec;
   logic              taken;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   pc_scalar;

   // Decode inputs are held by the decoder for the whole EXEC state.
   assign vlen_zero = (vlen == '0);
   assign last_idx  = (idx_q == (vlen - 1'b1));
   assign accept    = !vlen_zero && (!is_vstreamout || so_ready);
   assign fin_vec   = vlen_zero || (accept && last_idx);
   assign taken     = is_bne && flag_neq;
   assign pc_inc    = pc_q + 1'b1;
   assign pc_scalar = taken ? branch_immediate : pc_inc;

   assign pc          = pc_q;
   assign vec_idx     = idx_q;
   assign busy        = (state_q != S_IDLE);
   assign done_steady = (state_q != S_STEADY);
`ifdef PC_LOOP_GUARD_EN
   assign loop_err    = err_q;
`endif

   // Next-state, PC/index update and per-cycle strobes.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      idx_d          = idx_q;
      stdy_d         = stdy_q;
      imem_rd_en     = 1'b0;
      vec_valid      = 1'b0;
      done_auto_incr = 1'b0;
      streamout_incr = 1'b0;
      done           = 1'b0;
`ifdef PC_LOOP_GUARD_EN
      taken_d        = taken_q;
      err_d          = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               idx_d   = '0;
               state_d = S_FETCH;
`ifdef PC_LOOP_GUARD_EN
               taken_d = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_FETCH: begin
            imem_rd_en = 1'b1;
            idx_d      = '0;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            if (is_not_vect) begin
`ifdef PC_LOOP_GUARD_EN
               if (taken && (taken_q == TK_MAX)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  if (taken) begin
                     taken_d = taken_q + 1'b1;
                  end
                  pc_d    = pc_scalar;
                  state_d = (pc_scalar == end_pc) ? S_DONE : S_FETCH;
               end
`else
               pc_d    = pc_scalar;
               state_d = (pc_scalar == end_pc) ? S_DONE : S_FETCH;
`endif
            end else begin
               vec_valid = !vlen_zero;
               if (accept) begin
                  idx_d = idx_q + 1'b1;
               end
               if (fin_vec) begin
                  done_auto_incr = !is_vstreamout;
                  streamout_incr = is_vstreamout;
                  pc_d           = pc_inc;
                  idx_d          = '0;
                  if (STEADY_LAT > 0) begin
                     stdy_d  = SL_LOAD;
                     state_d = S_STEADY;
                  end else begin
                     state_d = (pc_inc == end_pc) ? S_DONE : S_FETCH;
                  end
               end
            end
         end
         S_STEADY: begin
            if (stdy_q == '0) begin
               state_d = (pc_q == end_pc) ? S_DONE : S_FETCH;
            end else begin
               stdy_d = stdy_q - 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         idx_q   <= '0;
         stdy_q  <= '0;
`ifdef PC_LOOP_GUARD_EN
         taken_q <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         idx_q   <= idx_d;
         stdy_q  <= stdy_d;
`ifdef PC_LOOP_GUARD_EN
         taken_q <= taken_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_pe_pc_sequencer.sv
// tb_pe_pc_sequencer: directed and randomized program runs against a program-level model.
// Loop-guard checks are compiled in when PC_LOOP_GUARD_EN is defined.
module tb_pe_pc_sequencer;

   localparam int PC_W   = 12;
   localparam int VLEN_W = 16;
   localparam int SL     = 4;
`ifdef PC_LOOP_GUARD_EN
   localparam int MAX_ONES = 2;
`else
   localparam int MAX_ONES = 4;
`endif

   logic              ap_clk = 1'b0;
   logic              ap_rst_n;
   logic              start;
   logic [PC_W-1:0]   end_pc;
   logic [VLEN_W-1:0] vlen;
   logic              is_not_vect;
   logic              is_bne;
   logic              flag_neq;
   logic              is_vstreamout;
   logic [PC_W-1:0]   branch_immediate;
   logic              so_ready;
   logic [PC_W-1:0]   pc;
   logic              imem_rd_en;
   logic              vec_valid;
   logic [VLEN_W-1:0] vec_idx;
   logic              done_auto_incr;
   logic              streamout_incr;
   logic              done_steady;
   logic              busy;
   logic              done;
`ifdef PC_LOOP_GUARD_EN
   logic              loop_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int p_kind[16];
   int p_bne[16];
   int p_tgt[16];
   int p_vlen[16];
   int p_end;
   int fl[$];
   int last_f[$];

   always #5 ap_clk = ~ap_clk;

   pe_pc_sequencer #(
      .PC_W(PC_W),
      .VLEN_W(VLEN_W),
      .STEADY_LAT(SL)
`ifdef PC_LOOP_GUARD_EN
      ,
      .MAX_TAKEN(2)
`endif
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst_n(ap_rst_n),
      .start(start),
      .end_pc(end_pc),
      .vlen(vlen),
      .is_not_vect(is_not_vect),
      .is_bne(is_bne),
      .flag_neq(flag_neq),
      .is_vstreamout(is_vstreamout),
      .branch_immediate(branch_immediate),
      .so_ready(so_ready),
      .pc(pc),
      .imem_rd_en(imem_rd_en),
      .vec_valid(vec_valid),
      .vec_idx(vec_idx),
      .done_auto_incr(done_auto_incr),
      .streamout_incr(streamout_incr),
      .done_steady(done_steady),
      .busy(busy),
`ifdef PC_LOOP_GUARD_EN
      .loop_err(loop_err),
`endif
      .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 60) begin
         step();
         n++;
      end
      chk({tag, " done"}, 32'(done), 1);
      step();
   endtask

   // Program-level model: walks the program, then runs the DUT and compares traces.
   task automatic run_program(input string tag);
      int mpc, fi, f, guard, dfi, cyc, st_low, n_auto, n_so;
      int m_auto, m_so, m_vec, pc_done;
      bit got;
      int exp_f[$];
      int exp_i[$];
      int obs_i[$];
      logic [3:0] a;
      mpc = 0; fi = 0; m_auto = 0; m_so = 0; m_vec = 0; guard = 0;
      do begin
         exp_f.push_back(mpc);
         if (p_kind[mpc] == 0) begin
            if (p_bne[mpc] != 0) begin
               f = (fi < fl.size()) ? fl[fi] : 0;
               fi++;
               mpc = (f != 0) ? p_tgt[mpc] : mpc + 1;
            end else begin
               mpc = mpc + 1;
            end
         end else begin
            for (int e = 0; e < p_vlen[mpc]; e++) exp_i.push_back(e);
            if (p_kind[mpc] == 1) m_auto++;
            else m_so++;
            m_vec++;
            mpc++;
         end
         guard++;
      end while (mpc != p_end && guard < 500);

      last_f.delete();
      end_pc = PC_W'(p_end);
      dfi = 0; st_low = 0; n_auto = 0; n_so = 0; got = 0; pc_done = -1; cyc = 0;
      start = 1'b1;
      while (!got && cyc < 3000) begin
         step();
         start = 1'b0;
         if (imem_rd_en) begin
            a = pc[3:0];
            last_f.push_back(int'(pc));
            is_not_vect      = (p_kind[a] == 0);
            is_vstreamout    = (p_kind[a] == 2);
            is_bne           = (p_kind[a] == 0) && (p_bne[a] != 0);
            branch_immediate = PC_W'(p_tgt[a]);
            vlen             = VLEN_W'(p_vlen[a]);
            flag_neq         = 1'b0;
            if (is_bne) begin
               flag_neq = (dfi < fl.size()) ? (fl[dfi] != 0) : 1'b0;
               dfi++;
            end
         end
         so_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (vec_valid && (!is_vstreamout || so_ready)) obs_i.push_back(int'(vec_idx));
         if (done_auto_incr) n_auto++;
         if (streamout_incr) n_so++;
         if (!done_steady) st_low++;
         if (done) begin
            got = 1'b1;
            pc_done = int'(pc);
         end
         cyc++;
      end
      chk({tag, " done seen"}, 32'(got), 1);
      chk({tag, " pc at done"}, pc_done, p_end);
      chk({tag, " fetch count"}, last_f.size(), exp_f.size());
      for (int i = 0; i < exp_f.size(); i++)
         chk({tag, " fetch pc"}, (i < last_f.size()) ? last_f[i] : -1, exp_f[i]);
      chk({tag, " elem count"}, obs_i.size(), exp_i.size());
      for (int i = 0; i < exp_i.size(); i++)
         chk({tag, " elem idx"}, (i < obs_i.size()) ? obs_i[i] : -1, exp_i[i]);
      chk({tag, " auto pulses"}, n_auto, m_auto);
      chk({tag, " so pulses"}, n_so, m_so);
      chk({tag, " steady low"}, st_low, SL * m_vec);
      step();
      chk({tag, " idle busy"}, 32'(busy), 0);
      chk({tag, " idle done"}, 32'(done), 0);
   endtask

   initial begin
      int bne_exp[7];
      int nf, n, ones, b;
      bne_exp = '{0, 1, 0, 1, 0, 1, 2};
      ap_rst_n = 1'b0; start = 1'b0; end_pc = '0; vlen = '0;
      is_not_vect = 1'b1; is_bne = 1'b0; flag_neq = 1'b0; is_vstreamout = 1'b0;
      branch_immediate = '0; so_ready = 1'b1;
      step();
      step();
      chk("rst pc", 32'(pc), 0);
      chk("rst idx", 32'(vec_idx), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst steady", 32'(done_steady), 1);
      chk("rst imem", 32'(imem_rd_en), 0);
      chk("rst valid", 32'(vec_valid), 0);
      chk("rst done", 32'(done), 0);
      chk("rst pulses", 32'({done_auto_incr, streamout_incr}), 0);
`ifdef PC_LOOP_GUARD_EN
      chk("rst loop_err", 32'(loop_err), 0);
`endif
      ap_rst_n = 1'b1;

      // Scalars, end_pc = 3.
      end_pc = 12'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("sc fetch", 32'(imem_rd_en), 1);
         chk("sc pc", 32'(pc), k);
         step();
         chk("sc exec", 32'(imem_rd_en), 0);
         step();
      end
      chk("sc done", 32'(done), 1);
      chk("sc end pc", 32'(pc), 3);
      step();
      chk("sc done gone", 32'(done), 0);
      chk("sc busy", 32'(busy), 0);

      // Vector vlen = 4.
      end_pc = 12'd1; is_not_vect = 1'b0; is_vstreamout = 1'b0; vlen = 16'd4;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("vec fetch", 32'(imem_rd_en), 1);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("vec valid", 32'(vec_valid), 1);
         chk("vec idx", 32'(vec_idx), i);
         chk("vec auto", 32'(done_auto_incr), 32'(i == 3));
         step();
      end
      for (int j = 0; j < 4; j++) begin
         chk("vec steady low", 32'(done_steady), 0);
         chk("vec no valid", 32'(vec_valid), 0);
         step();
      end
      chk("vec steady high", 32'(done_steady), 1);
      chk("vec done", 32'(done), 1);
      chk("vec pc", 32'(pc), 1);
      step();

      // Stream-out vlen = 3 with a 2-cycle stall at idx 1.
      is_vstreamout = 1'b1; vlen = 16'd3; so_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("so idx0", 32'(vec_idx), 0);
      chk("so no pulse0", 32'(streamout_incr), 0);
      step();
      so_ready = 1'b0;
      #1;
      chk("so stall a", 32'(vec_idx), 1);
      step();
      chk("so stall b", 32'(vec_idx), 1);
      chk("so stall valid", 32'(vec_valid), 1);
      step();
      so_ready = 1'b1;
      #1;
      chk("so accept1", 32'(vec_idx), 1);
      chk("so no pulse1", 32'(streamout_incr), 0);
      step();
      chk("so idx2", 32'(vec_idx), 2);
      chk("so pulse", 32'(streamout_incr), 1);
      chk("so no auto", 32'(done_auto_incr), 0);
      wait_done("so");

      // Reset in the middle of a vector op.
      end_pc = 12'd5; is_not_vect = 1'b1; is_vstreamout = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      is_not_vect = 1'b0; vlen = 16'd8;
      for (int i = 0; i < 4; i++) step();
      chk("mid idx", 32'(vec_idx), 3);
      chk("mid pc", 32'(pc), 1);
      ap_rst_n = 1'b0;
      step();
      chk("mrst pc", 32'(pc), 0);
      chk("mrst valid", 32'(vec_valid), 0);
      chk("mrst busy", 32'(busy), 0);
      chk("mrst steady", 32'(done_steady), 1);
      chk("mrst idx", 32'(vec_idx), 0);
      ap_rst_n = 1'b1;

      // bne loop back to 0, taken twice.
      for (int i = 0; i < 16; i++) begin
         p_kind[i] = 0; p_bne[i] = 0; p_tgt[i] = 0; p_vlen[i] = 0;
      end
      p_end = 3; p_bne[1] = 1; p_tgt[1] = 0;
      fl.delete();
      fl.push_back(1); fl.push_back(1); fl.push_back(0);
      run_program("bne");
      chk("bne n", last_f.size(), 7);
      for (int i = 0; i < 7; i++)
         chk("bne seq", (i < last_f.size()) ? last_f[i] : -1, bne_exp[i]);

      // Zero-length vector and stream-out.
      for (int i = 0; i < 16; i++) begin
         p_kind[i] = 0; p_bne[i] = 0; p_tgt[i] = 0; p_vlen[i] = 0;
      end
      p_end = 2; p_kind[0] = 1; p_kind[1] = 2;
      fl.delete();
      run_program("vlen0");

`ifdef PC_LOOP_GUARD_EN
      // Always-taken branch trips the guard on the 3rd taken branch.
      end_pc = 12'd1; is_not_vect = 1'b1; is_bne = 1'b1; flag_neq = 1'b1;
      branch_immediate = '0; is_vstreamout = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      nf = 0; n = 0;
      while (!done && n < 60) begin
         if (imem_rd_en) nf++;
         step();
         n++;
      end
      chk("guard done", 32'(done), 1);
      chk("guard err", 32'(loop_err), 1);
      chk("guard fetches", nf, 3);
      step();
      chk("guard sticky", 32'(loop_err), 1);
      ap_rst_n = 1'b0;
      step();
      chk("guard rst", 32'(loop_err), 0);
      ap_rst_n = 1'b1;
`else
      nf = 0; n = 0;
`endif

      // Random programs.
      for (int t = 0; t < 40; t++) begin
         p_end = $urandom_range(1, 10);
         for (int i = 0; i < 16; i++) begin
            p_kind[i] = $urandom_range(0, 2);
            p_bne[i]  = $urandom_range(0, 1);
            p_tgt[i]  = $urandom_range(0, p_end);
            p_vlen[i] = $urandom_range(0, 6);
         end
         fl.delete();
         ones = 0;
         for (int i = 0; i < 6; i++) begin
            b = $urandom_range(0, 1);
            if (ones >= MAX_ONES) b = 0;
            ones += b;
            fl.push_back(b);
         end
         run_program("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
